// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - writeback stage bus interface
//
// Purpose: bundles the ALU result, memory-path result handshake, issue
//   scoreboard and register-file write port signals of reg_writeback_unit.
// Optional: WB_BYPASS_EN adds the byp_addr/byp_hit/byp_data forwarding port.
// Modports:
//   slave  - the writeback unit (consumes results, drives write port)
//   master - the surrounding pipeline / testbench
// Signals:
//   alu_valid/alu_dst/alu_data        ALU result, no back-pressure
//   mem_valid/mem_ready/mem_dst/mem_data  memory-path result handshake
//   issue_valid/issue_dst             memory-path destination being issued
//   pending[7:0]                      outstanding memory-path writes
//   wr_en/wr0_addr/wr0_data           register-file write port
interface reg_writeback_unit_if;
  logic        alu_valid;
  logic [2:0]  alu_dst;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dst;
  logic [15:0] mem_data;
  logic        issue_valid;
  logic [2:0]  issue_dst;
  logic [7:0]  pending;
  logic        wr_en;
  logic [2:0]  wr0_addr;
  logic [15:0] wr0_data;
`ifdef WB_BYPASS_EN
  logic [2:0]  byp_addr;
  logic        byp_hit;
  logic [15:0] byp_data;
`endif

  modport slave (
    input  alu_valid, alu_dst, alu_data,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready,
    input  issue_valid, issue_dst,
    output pending,
    output wr_en, wr0_addr, wr0_data
`ifdef WB_BYPASS_EN
    ,
    input  byp_addr,
    output byp_hit, byp_data
`endif
  );

  modport master (
    output alu_valid, alu_dst, alu_data,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready,
    output issue_valid, issue_dst,
    input  pending,
    input  wr_en, wr0_addr, wr0_data
`ifdef WB_BYPASS_EN
    ,
    output byp_addr,
    input  byp_hit, byp_data
`endif
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - writeback arbiter feeding the 8x16 register file
//
// Purpose: merges single-cycle ALU results and buffered memory-path results
//   onto the register file's single registered write port. ALU has fixed
//   priority; memory results wait in a 2-entry FIFO. An 8-bit scoreboard
//   tracks registers with outstanding memory-path writes.
// Optional: WB_BYPASS_EN adds a combinational forwarding port.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - reg_writeback_unit_if.slave (results, handshake, scoreboard,
//          write port, optional bypass)
module reg_writeback_unit (
  input  logic                  clk,
  input  logic                  rst,
  reg_writeback_unit_if.slave   bus
);

  logic        wr_en_q;
  logic [2:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic [7:0]  pending_q;
  logic [7:0]  pending_d;

  // FIFO entry layout: {dst[2:0], data[15:0]}
  logic [18:0] fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        mem_ready_w;
  logic        push;
  logic        pop;
  logic [2:0]  head_dst;
  logic [15:0] head_data;

  // Readiness comes only from the registered count, so a pop in the same
  // cycle as a full FIFO never lets a new entry in.
  assign mem_ready_w = !rst && (count != 2'd2);
  assign push        = bus.mem_valid && mem_ready_w;
  assign pop         = !bus.alu_valid && (count != 2'd0);
  assign head_dst    = fifo_mem[rd_ptr][18:16];
  assign head_data   = fifo_mem[rd_ptr][15:0];

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_dst] = 1'b0;
    end
    if (bus.issue_valid) begin
      pending_d[bus.issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= 3'd0;
      wr_data_q <= 16'd0;
      pending_q <= 8'h00;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      wr_en_q   <= bus.alu_valid || pop;
      pending_q <= pending_d;

      if (bus.alu_valid) begin
        wr_addr_q <= bus.alu_dst;
        wr_data_q <= bus.alu_data;
      end else if (pop) begin
        wr_addr_q <= head_dst;
        wr_data_q <= head_data;
      end

      if (push) begin
        fifo_mem[wr_ptr] <= {bus.mem_dst, bus.mem_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.mem_ready = mem_ready_w;
  assign bus.pending   = pending_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr0_addr  = wr_addr_q;
  assign bus.wr0_data  = wr_data_q;

`ifdef WB_BYPASS_EN
  // Lets decode see the value being written this cycle, one cycle before
  // the register file holds it.
  assign bus.byp_hit  = wr_en_q && (wr_addr_q == bus.byp_addr);
  assign bus.byp_data = bus.byp_hit ? wr_data_q : 16'd0;
`endif

endmodule
